wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between two result sources.
- Source one is the in-order pipeline write-back stream, which arrives one result per cycle.
- Source two is a multi-cycle unit (mul/div, late load), whose results are buffered in a small pending FIFO.
- Arbitration favours the pipeline, with starvation protection for the multi-cycle unit.
- Sits between the write-back stage and the register file; drives the registered RF write port.

---
 rtl/wb_port_arbiter.sv | 134 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the pipeline write-back stream has priority, and
// multi-cycle results wait in a small pending FIFO that has starvation protection.
module wb_port_arbiter #(
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned PEND_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_valid,
  input  logic [4:0]        pipe_addr,
  input  logic [DATA_W-1:0] pipe_data,
  output logic              pipe_ready,
  input  logic              mdu_valid,
  input  logic [4:0]        mdu_addr,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              mdu_ready,
  output logic              rf_wen,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [4:0]        chk_addr,
  output logic              pend_hit,
  output logic              pend_busy
);

  localparam int unsigned PTR_W = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(PEND_DEPTH + 1);
  localparam int unsigned STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef struct packed {
    logic [4:0]        addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            mem_q [PEND_DEPTH];
  entry_t            mem_d [PEND_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              rf_wen_q, rf_wen_d;
  logic [4:0]        rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  logic   force_c;
  logic   grant_pipe;
  logic   grant_fifo;
  logic   push;
  entry_t head;

  // Grant decision: the FIFO wins when forced, or when the pipeline is idle
  assign pend_busy  = (count_q != '0);
  assign force_c    = pend_busy && (starve_q >= STV_W'(STARVE_LIMIT));
  assign pipe_ready = !force_c;
  assign mdu_ready  = (count_q < CNT_W'(PEND_DEPTH));
  assign grant_pipe = !force_c && pipe_valid;
  assign grant_fifo = pend_busy && (force_c || !pipe_valid);
  assign push       = mdu_valid && mdu_ready;
  assign head       = mem_q[rd_ptr_q];

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  // Hazard query over occupied slots; the head being popped still counts
  always_comb begin
    logic             hit;
    logic [PTR_W-1:0] offset;
    hit    = 1'b0;
    offset = '0;
    for (int i = 0; i < int'(PEND_DEPTH); i++) begin
      offset = PTR_W'(i) - rd_ptr_q;
      if ((CNT_W'(offset) < count_q) && (mem_q[i].addr == chk_addr)) hit = 1'b1;
    end
    pend_hit = hit && (chk_addr != 5'd0);
  end

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(grant_fifo);
    starve_d   = starve_q;
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;

    if (push) begin
      mem_d[wr_ptr_q] = '{addr: mdu_addr, data: mdu_data};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (grant_fifo) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (grant_fifo || !pend_busy) begin
      starve_d = '0;
    end else if (grant_pipe && (starve_q < STV_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + STV_W'(1);
    end

    // x0 destinations are consumed and latched but never written
    if (grant_pipe) begin
      rf_waddr_d = pipe_addr;
      rf_wdata_d = pipe_data;
      rf_wen_d   = (pipe_addr != 5'd0);
    end else if (grant_fifo) begin
      rf_waddr_d = head.addr;
      rf_wdata_d = head.data;
      rf_wen_d   = (head.addr != 5'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(PEND_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed, table-driven bench for wb_port_arbiter (default parameters) plus a reset-mid-operation sequence.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        pipe_valid;
  logic [4:0]  pipe_addr;
  logic [63:0] pipe_data;
  logic        pipe_ready;
  logic        mdu_valid;
  logic [4:0]  mdu_addr;
  logic [63:0] mdu_data;
  logic        mdu_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [4:0]  chk_addr;
  logic        pend_hit;
  logic        pend_busy;

  wb_port_arbiter #(.DATA_W(64), .PEND_DEPTH(2), .STARVE_LIMIT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_valid(pipe_valid), .pipe_addr(pipe_addr), .pipe_data(pipe_data), .pipe_ready(pipe_ready),
    .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .chk_addr(chk_addr), .pend_hit(pend_hit), .pend_busy(pend_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [4:0]  pa;
    logic [63:0] pd;
    logic        mv;
    logic [4:0]  ma;
    logic [63:0] md;
    logic [4:0]  chk;
    logic        e_pr;
    logic        e_mr;
    logic        e_hit;
    logic        e_busy;
    logic        e_wen;
    logic [4:0]  e_wa;
    logic [63:0] e_wd;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    else n_pass++;
  endtask

  function automatic void add(input logic pv, input logic [4:0] pa, input logic [63:0] pd,
                              input logic mv, input logic [4:0] ma, input logic [63:0] md,
                              input logic [4:0] chk, input logic e_pr, input logic e_mr,
                              input logic e_hit, input logic e_busy, input logic e_wen,
                              input logic [4:0] e_wa, input logic [63:0] e_wd);
    vec_t v;
    v.pv = pv; v.pa = pa; v.pd = pd; v.mv = mv; v.ma = ma; v.md = md; v.chk = chk;
    v.e_pr = e_pr; v.e_mr = e_mr; v.e_hit = e_hit; v.e_busy = e_busy;
    v.e_wen = e_wen; v.e_wa = e_wa; v.e_wd = e_wd;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic pv, input logic [4:0] pa, input logic [63:0] pd,
                       input logic mv, input logic [4:0] ma, input logic [63:0] md, input logic [4:0] chk);
    pipe_valid = pv; pipe_addr = pa; pipe_data = pd;
    mdu_valid  = mv; mdu_addr  = ma; mdu_data  = md;
    chk_addr   = chk;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // pv pa pd | mv ma md | chk || pipe_rdy mdu_rdy hit busy (before edge) || wen waddr wdata (after edge)
    // Pipeline stream
    add(1, 1, 64'h10, 0, 0, 0, 0,  1, 1, 0, 0,  1, 1, 64'h10);
    add(1, 2, 64'h20, 0, 0, 0, 0,  1, 1, 0, 0,  1, 2, 64'h20);
    add(1, 3, 64'h30, 0, 0, 0, 0,  1, 1, 0, 0,  1, 3, 64'h30);
    add(1, 4, 64'h40, 0, 0, 0, 0,  1, 1, 0, 0,  1, 4, 64'h40);
    add(1, 5, 64'h50, 0, 0, 0, 0,  1, 1, 0, 0,  1, 5, 64'h50);
    add(0, 0, 0,      0, 0, 0, 0,  1, 1, 0, 0,  0, 5, 64'h50);
    // Single MDU result with an idle pipeline: written two cycles after the push
    add(0, 0, 0, 1, 7, 64'hABCD, 0,  1, 1, 0, 0,  0, 5, 64'h50);
    add(0, 0, 0, 0, 0, 0,        7,  1, 1, 1, 1,  1, 7, 64'hABCD);
    add(0, 0, 0, 0, 0, 0,        7,  1, 1, 0, 0,  0, 7, 64'hABCD);
    // Starvation: the pipe wins three times, then is held off for one cycle
    add(1, 1, 64'h100, 1, 8, 64'h800, 0,  1, 1, 0, 0,  1, 1, 64'h100);
    add(1, 2, 64'h200, 0, 0, 0,       8,  1, 1, 1, 1,  1, 2, 64'h200);
    add(1, 3, 64'h300, 0, 0, 0,       8,  1, 1, 1, 1,  1, 3, 64'h300);
    add(1, 4, 64'h400, 0, 0, 0,       8,  1, 1, 1, 1,  1, 4, 64'h400);
    add(1, 5, 64'h500, 0, 0, 0,       8,  0, 1, 1, 1,  1, 8, 64'h800);
    add(1, 5, 64'h500, 0, 0, 0,       8,  1, 1, 0, 0,  1, 5, 64'h500);
    // Three MDU pushes against a busy pipe: the FIFO fills and the third push waits
    add(1,  6, 64'h600,  1, 10, 64'hA0, 0,  1, 1, 0, 0,  1,  6, 64'h600);
    add(1, 12, 64'h1200, 1, 11, 64'hB0, 0,  1, 1, 0, 1,  1, 12, 64'h1200);
    add(1, 13, 64'h1300, 1, 14, 64'hC0, 0,  1, 0, 0, 1,  1, 13, 64'h1300);
    add(1, 15, 64'h1500, 1, 14, 64'hC0, 0,  1, 0, 0, 1,  1, 15, 64'h1500);
    add(1, 16, 64'h1600, 1, 14, 64'hC0, 0,  0, 0, 0, 1,  1, 10, 64'hA0);
    add(1, 16, 64'h1600, 1, 14, 64'hC0, 0,  1, 1, 0, 1,  1, 16, 64'h1600);
    add(1, 17, 64'h1700, 0, 0, 0,       0,  1, 0, 0, 1,  1, 17, 64'h1700);
    add(1, 18, 64'h1800, 0, 0, 0,       0,  1, 0, 0, 1,  1, 18, 64'h1800);
    add(1, 19, 64'h1900, 0, 0, 0,       0,  0, 0, 0, 1,  1, 11, 64'hB0);
    add(0, 0, 0,         0, 0, 0,       0,  1, 1, 0, 1,  1, 14, 64'hC0);
    add(0, 0, 0,         0, 0, 0,       0,  1, 1, 0, 0,  0, 14, 64'hC0);
    // x0 writes are consumed silently; hazard lookup against a pending entry
    add(1, 0, 64'hFFFF, 0, 0, 0,     0,  1, 1, 0, 0,  0, 0, 64'hFFFF);
    add(0, 0, 0,        1, 9, 64'h99, 9,  1, 1, 0, 0,  0, 0, 64'hFFFF);
    add(1, 1, 64'h1,    0, 0, 0,     9,  1, 1, 1, 1,  1, 1, 64'h1);
    add(1, 2, 64'h2,    0, 0, 0,     0,  1, 1, 0, 1,  1, 2, 64'h2);
    add(0, 0, 0,        0, 0, 0,     9,  1, 1, 1, 1,  1, 9, 64'h99);
    add(0, 0, 0,        1, 0, 64'h77, 0,  1, 1, 0, 0,  0, 9, 64'h99);
    add(0, 0, 0,        0, 0, 0,     0,  1, 1, 0, 1,  0, 0, 64'h77);
    add(0, 0, 0,        0, 0, 0,     0,  1, 1, 0, 0,  0, 0, 64'h77);

    // Power-on reset
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("rst_wen",   0, 64'(rf_wen),    64'd0);
    check("rst_waddr", 0, 64'(rf_waddr),  64'd0);
    check("rst_wdata", 0, rf_wdata,       64'd0);
    check("rst_busy",  0, 64'(pend_busy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rel_pipe_ready", 0, 64'(pipe_ready), 64'd1);
    check("rel_mdu_ready",  0, 64'(mdu_ready),  64'd1);

    foreach (vecs[i]) begin
      drive(vecs[i].pv, vecs[i].pa, vecs[i].pd, vecs[i].mv, vecs[i].ma, vecs[i].md, vecs[i].chk);
      #1;
      check("pipe_ready", i, 64'(pipe_ready), 64'(vecs[i].e_pr));
      check("mdu_ready",  i, 64'(mdu_ready),  64'(vecs[i].e_mr));
      check("pend_hit",   i, 64'(pend_hit),   64'(vecs[i].e_hit));
      check("pend_busy",  i, 64'(pend_busy),  64'(vecs[i].e_busy));
      step();
      check("rf_wen",     i, 64'(rf_wen),     64'(vecs[i].e_wen));
      check("rf_waddr",   i, 64'(rf_waddr),   64'(vecs[i].e_wa));
      check("rf_wdata",   i, rf_wdata,        vecs[i].e_wd);
    end

    // Reset in the middle of traffic: two entries pending and a write in flight
    drive(1, 3, 64'h33, 1, 20, 64'h2000, 0);
    step();
    drive(1, 4, 64'h44, 1, 21, 64'h2100, 0);
    step();
    check("mid_wen",       0, 64'(rf_wen),    64'd1);
    check("mid_busy",      0, 64'(pend_busy), 64'd1);
    check("mid_mdu_ready", 0, 64'(mdu_ready), 64'd0);
    drive(0, 0, 0, 0, 0, 0, 21);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_wen",   0, 64'(rf_wen),    64'd0);
    check("arst_busy",  0, 64'(pend_busy), 64'd0);
    check("arst_waddr", 0, 64'(rf_waddr),  64'd0);
    check("arst_hit",   0, 64'(pend_hit),  64'd0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("post_wen",   c, 64'(rf_wen),     64'd0);
      check("post_busy",  c, 64'(pend_busy),  64'd0);
      check("post_ready", c, 64'(mdu_ready),  64'd1);
      check("post_pipe",  c, 64'(pipe_ready), 64'd1);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
